// File: rtl/sort_src_stream.sv
// Streams a sorted packet out of RAM as an Avalon-ST source.
// Reads addresses 0..len-1 on a one-cycle-latency RAM port and presents the
// words with sop/eop framing; a 2-entry skid buffer absorbs in-flight reads
// under backpressure. Optional macro SORT_SRC_ORDER_CHECK_EN adds a sticky
// ascending-order checker on accepted beats.
module sort_src_stream #(
   parameter int unsigned DWIDTH  = 10,
   parameter int unsigned ADDR_SZ = 10
) (
   input  logic               clk_i,
   input  logic               rst_n_i,
   input  logic               start_i,
   input  logic [ADDR_SZ:0]   len_i,
   output logic [ADDR_SZ-1:0] rd_addr_o,
   input  logic [DWIDTH-1:0]  q_i,
   output logic [DWIDTH-1:0]  src_data_o,
   output logic               src_valid_o,
   output logic               src_startofpacket_o,
   output logic               src_endofpacket_o,
   input  logic               src_ready_i,
   output logic               busy_o,
   output logic               done_o,
   output logic               order_err_o
);

   localparam int unsigned CW = ADDR_SZ + 1;

   typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

   state_t                       state_q, state_d;
   logic [CW-1:0]                cnt_q, cnt_d;
   logic [CW-1:0]                len_q, len_d;
   logic                         inflight_q, inflight_d;
   logic                         in_sop_q, in_sop_d;
   logic                         in_eop_q, in_eop_d;
   logic [1:0]                   fill_q, fill_d;
   logic [1:0][DWIDTH-1:0]       skid_data_q, skid_data_d;
   logic [1:0]                   skid_sop_q, skid_sop_d;
   logic [1:0]                   skid_eop_q, skid_eop_d;
   logic                         done_q, done_d;
   logic                         busy_q, busy_d;

   logic                         head_valid;
   logic [DWIDTH-1:0]            head_data;
   logic                         head_sop;
   logic                         head_eop;
   logic                         pop;
   logic                         start_acc;
   logic                         issue;
   logic [1:0]                   occ;

   // Output head: oldest skid entry first, else the read returning this cycle.
   always_comb begin
      head_valid = (fill_q != 2'd0) | inflight_q;
      head_data  = '0;
      head_sop   = 1'b0;
      head_eop   = 1'b0;
      if (fill_q != 2'd0) begin
         head_data = skid_data_q[0];
         head_sop  = skid_sop_q[0];
         head_eop  = skid_eop_q[0];
      end else if (inflight_q) begin
         head_data = q_i;
         head_sop  = in_sop_q;
         head_eop  = in_eop_q;
      end
   end

   assign pop       = head_valid & src_ready_i;
   assign start_acc = (state_q == IDLE) & start_i;
   // Words held or arriving this cycle; a new read is only issued when the
   // skid buffer can still take it even if the sink stalls from now on.
   assign occ       = fill_q + 2'(inflight_q);
   assign issue     = (state_q == READ) & (occ <= 2'd1);

   // Next-state, read sequencing and skid buffer update.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      len_d       = len_q;
      inflight_d  = 1'b0;
      in_sop_d    = in_sop_q;
      in_eop_d    = in_eop_q;
      skid_data_d = skid_data_q;
      skid_sop_d  = skid_sop_q;
      skid_eop_d  = skid_eop_q;
      fill_d      = occ - 2'(pop);
      done_d      = 1'b0;

      if (inflight_q) begin
         if (fill_q == 2'd0) begin
            skid_data_d[0] = q_i;
            skid_sop_d[0]  = in_sop_q;
            skid_eop_d[0]  = in_eop_q;
         end else begin
            skid_data_d[1] = q_i;
            skid_sop_d[1]  = in_sop_q;
            skid_eop_d[1]  = in_eop_q;
         end
      end
      if (pop) begin
         skid_data_d[0] = skid_data_d[1];
         skid_sop_d[0]  = skid_sop_d[1];
         skid_eop_d[0]  = skid_eop_d[1];
      end

      if (issue) begin
         inflight_d = 1'b1;
         in_sop_d   = (cnt_q == CW'(0));
         in_eop_d   = (cnt_q == len_q - CW'(1));
         cnt_d      = cnt_q + CW'(1);
      end

      case (state_q)
         IDLE: begin
            if (start_acc) begin
               cnt_d = '0;
               len_d = len_i;
               if (len_i != CW'(0)) state_d = READ;
               else                 done_d  = 1'b1;
            end
         end
         READ: begin
            if (issue && (cnt_q == len_q - CW'(1))) state_d = DRAIN;
         end
         DRAIN: begin
            if (pop && head_eop) begin
               state_d = IDLE;
               done_d  = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase

      busy_d = (state_d != IDLE) | done_d;
   end

   // State and datapath registers.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         len_q       <= '0;
         inflight_q  <= 1'b0;
         in_sop_q    <= 1'b0;
         in_eop_q    <= 1'b0;
         fill_q      <= 2'd0;
         skid_data_q <= '0;
         skid_sop_q  <= '0;
         skid_eop_q  <= '0;
         done_q      <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         len_q       <= len_d;
         inflight_q  <= inflight_d;
         in_sop_q    <= in_sop_d;
         in_eop_q    <= in_eop_d;
         fill_q      <= fill_d;
         skid_data_q <= skid_data_d;
         skid_sop_q  <= skid_sop_d;
         skid_eop_q  <= skid_eop_d;
         done_q      <= done_d;
         busy_q      <= busy_d;
      end
   end

   assign rd_addr_o           = cnt_q[ADDR_SZ-1:0];
   assign src_valid_o         = head_valid;
   assign src_data_o          = head_data;
   assign src_startofpacket_o = head_sop;
   assign src_endofpacket_o   = head_eop;
   assign busy_o              = busy_q;
   assign done_o              = done_q;

`ifdef SORT_SRC_ORDER_CHECK_EN
   logic [DWIDTH-1:0] prev_q, prev_d;
   logic              prev_vld_q, prev_vld_d;
   logic              order_err_q, order_err_d;

   // Compare each accepted beat with the previous one of the same packet.
   always_comb begin
      prev_d      = prev_q;
      prev_vld_d  = prev_vld_q;
      order_err_d = order_err_q;
      if (start_acc) begin
         prev_vld_d  = 1'b0;
         order_err_d = 1'b0;
      end else if (pop) begin
         prev_d     = head_data;
         prev_vld_d = 1'b1;
         if (prev_vld_q && (head_data < prev_q)) order_err_d = 1'b1;
      end
   end

   // Order checker registers.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         prev_q      <= '0;
         prev_vld_q  <= 1'b0;
         order_err_q <= 1'b0;
      end else begin
         prev_q      <= prev_d;
         prev_vld_q  <= prev_vld_d;
         order_err_q <= order_err_d;
      end
   end

   assign order_err_o = order_err_q;
`else
   assign order_err_o = 1'b0;
`endif

endmodule
